floating_point_accumulator: RTL and testbench

//   Streaming reduction stage wrapped around floating_point_adder: accepts a packet of floats on a

---
 rtl/floating_point_accumulator.sv | 213 +++++++++++++++++++++
 tb/tb_floating_point_accumulator.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floating_point_accumulator.sv
// Packet-sum reduction stage around a combinational float adder.
// Ports: in_* valid/ready element stream, out_* valid/ready packet result.

module floating_point_adder #(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1,
  parameter int ROUNDING_BITS    = 3
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  input  logic                                   subtract,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result,
  output logic                                   underflow_flag,
  output logic                                   overflow_flag,
  output logic                                   invalid_operation_flag
);
  localparam int E  = EXPONENT_WIDTH;
  localparam int M  = MANTISSA_WIDTH;
  localparam int R  = ROUNDING_BITS;
  localparam int W  = E + M + 1;
  localparam int SW = M + 1 + R;
  localparam logic [E+1:0] EMAX = {2'b00, {E{1'b1}}};
  localparam logic [R-1:0] HALF = {1'b1, {(R-1){1'b0}}};

  logic          sa, sb, s_big, eff_sub, swap;
  logic          a_nan, b_nan, a_inf, b_inf;
  logic          round_up;
  logic [E-1:0]  ea, eb, e_big, e_small, diff, e_field;
  logic [M-1:0]  ma, mb;
  logic [SW-1:0] sig_big, sig_small, sig_sh, mask, norm;
  logic [SW:0]   sum;
  logic [E+1:0]  exp_r;
  logic [M+1:0]  mant_r;
  logic [R-1:0]  rem;
  int            msb, shift, lim;

  always_comb begin
    sa      = a[W-1];
    ea      = a[W-2:M];
    ma      = a[M-1:0];
    sb      = b[W-1] ^ subtract;
    eb      = b[W-2:M];
    mb      = b[M-1:0];
    a_nan   = (&ea) & (|ma);
    b_nan   = (&eb) & (|mb);
    a_inf   = (&ea) & ~(|ma);
    b_inf   = (&eb) & ~(|mb);
    eff_sub = sa ^ sb;
    swap    = b[W-2:0] > a[W-2:0];
    s_big   = swap ? sb : sa;
    e_big   = swap ? eb : ea;
    e_small = swap ? ea : eb;
    sig_big   = swap ? {|eb, mb, {R{1'b0}}}
                     : {|ea, ma, {R{1'b0}}};
    sig_small = swap ? {|ea, ma, {R{1'b0}}}
                     : {|eb, mb, {R{1'b0}}};
    // subnormals share the exponent of the smallest normal
    if (e_big == '0) e_big = E'(1);
    if (e_small == '0) e_small = E'(1);
    diff   = e_big - e_small;
    mask   = (SW'(1) << diff) - SW'(1);
    sig_sh = sig_small >> diff;
    sig_sh[0] = sig_sh[0] | (|(sig_small & mask));
    if (eff_sub) sum = {1'b0, sig_big} - {1'b0, sig_sh};
    else         sum = {1'b0, sig_big} + {1'b0, sig_sh};
    exp_r = {2'b00, e_big};
    msb   = 0;
    for (int i = 0; i < SW; i++)
      if (sum[i]) msb = i;
    norm  = sum[SW-1:0];
    shift = 0;
    lim   = 0;
    if (sum[SW]) begin
      norm    = sum[SW:1];
      norm[0] = norm[0] | sum[0];
      exp_r   = exp_r + 1'b1;
    end else begin
      // left shift limited so tiny results land as subnormals
      shift = SW - 1 - msb;
      lim   = int'(exp_r) - 1;
      if (shift > lim) shift = lim;
      norm  = norm << shift;
      exp_r = exp_r - (E+2)'(shift);
    end
    rem      = norm[R-1:0];
    round_up = (ROUND_TO_NEAREST != 0) &&
               ((rem > HALF) || ((rem == HALF) && norm[R]));
    mant_r   = {1'b0, norm[SW-1:R]} + (M+2)'(round_up);
    if (mant_r[M+1]) begin
      exp_r  = exp_r + 1'b1;
      mant_r = mant_r >> 1;
    end
    e_field = mant_r[M] ? exp_r[E-1:0] : E'(0);

    result                 = '0;
    underflow_flag         = 1'b0;
    overflow_flag          = 1'b0;
    invalid_operation_flag = 1'b0;
    if (a_nan | b_nan | (a_inf & b_inf & eff_sub)) begin
      result = {1'b1, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      invalid_operation_flag = 1'b1;
    end else if (a_inf | b_inf) begin
      result = {a_inf ? sa : sb, {E{1'b1}}, {M{1'b0}}};
    end else if (sum == '0) begin
      result = {sa & sb, {(W-1){1'b0}}};
    end else if (exp_r >= EMAX) begin
      result        = {s_big, {E{1'b1}}, {M{1'b0}}};
      overflow_flag = 1'b1;
    end else begin
      result         = {s_big, e_field, mant_r[M-1:0]};
      underflow_flag = ~mant_r[M];
    end
  end
endmodule

module floating_point_accumulator #(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1,
  parameter int ROUNDING_BITS    = 3,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_data,
  input  logic                                   in_subtract,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_data,
  output logic [COUNT_WIDTH-1:0]                 out_count,
  output logic                                   out_underflow,
  output logic                                   out_overflow,
  output logic                                   out_invalid
);
  localparam int W = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic             first;
  logic             accept;
  logic [W-1:0]     acc;
  logic [W-1:0]     add_res;
  logic             add_uf, add_of, add_inv;

  floating_point_adder #(
    .EXPONENT_WIDTH  (EXPONENT_WIDTH),
    .MANTISSA_WIDTH  (MANTISSA_WIDTH),
    .ROUND_TO_NEAREST(ROUND_TO_NEAREST),
    .ROUNDING_BITS   (ROUNDING_BITS)
  ) u_add (
    .a                     (acc),
    .b                     (in_data),
    .subtract              (in_subtract),
    .result                (add_res),
    .underflow_flag        (add_uf),
    .overflow_flag         (add_of),
    .invalid_operation_flag(add_inv)
  );

  // gated with rst_n so the block never advertises ready in reset
  assign in_ready  = rst_n & (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign out_data  = acc;
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ACCUM;
      first         <= 1'b1;
      acc           <= '0;
      out_count     <= '0;
      out_underflow <= 1'b0;
      out_overflow  <= 1'b0;
      out_invalid   <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            if (first) begin
              acc   <= {in_data[W-1] ^ in_subtract,
                        in_data[W-2:0]};
              first <= 1'b0;
            end else begin
              acc           <= add_res;
              out_underflow <= out_underflow | add_uf;
              out_overflow  <= out_overflow | add_of;
              out_invalid   <= out_invalid | add_inv;
            end
            if (~&out_count) out_count <= out_count + 1'b1;
            if (in_last) state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state         <= ACCUM;
            first         <= 1'b1;
            acc           <= '0;
            out_count     <= '0;
            out_underflow <= 1'b0;
            out_overflow  <= 1'b0;
            out_invalid   <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_floating_point_accumulator.sv
// Directed bench for floating_point_accumulator (fp32).
// Each task drives one scenario and checks hand-computed results.

module tb_floating_point_accumulator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_subtract;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic        out_underflow;
  logic        out_overflow;
  logic        out_invalid;

  int pass_cnt = 0;
  int total_cnt = 0;

  floating_point_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_subtract  (in_subtract),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count),
    .out_underflow(out_underflow),
    .out_overflow (out_overflow),
    .out_invalid  (out_invalid)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic [31:0] d, input logic s,
                      input logic l);
    @(negedge clk);
    in_valid    = 1'b1;
    in_data     = d;
    in_subtract = s;
    in_last     = l;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_subtract = 1'b0;
    in_last     = 1'b0;
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0)
      $display("FAIL rst_in_ready got %b want 0", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL rst_out_valid got %b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if ({out_data, out_count} !== 48'h0)
      $display("FAIL rst_data_count got %h/%0d want 0/0",
               out_data, out_count);
    else pass_cnt++;
    total_cnt++;
    if ({out_underflow, out_overflow, out_invalid} !== 3'b000)
      $display("FAIL rst_flags got %b want 000",
               {out_underflow, out_overflow, out_invalid});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL rel_in_ready got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_sum();
    beat(32'h3F800000, 1'b0, 1'b0);
    beat(32'h40000000, 1'b0, 1'b0);
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL sum_early_valid got %b want 0", out_valid);
    else pass_cnt++;
    beat(32'h40400000, 1'b0, 1'b1);
    total_cnt++;
    if (out_valid !== 1'b1)
      $display("FAIL sum_valid got %b want 1", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 32'h40C00000)
      $display("FAIL sum_data got %h want 40c00000", out_data);
    else pass_cnt++;
    total_cnt++;
    if (out_count !== 16'd3)
      $display("FAIL sum_count got %0d want 3", out_count);
    else pass_cnt++;
    total_cnt++;
    if ({out_underflow, out_overflow, out_invalid} !== 3'b000)
      $display("FAIL sum_flags got %b want 000",
               {out_underflow, out_overflow, out_invalid});
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0)
      $display("FAIL sum_hold_ready got %b want 0", in_ready);
    else pass_cnt++;
    take();
    total_cnt++;
    if ({out_valid, in_ready, out_count} !== {2'b01, 16'd0})
      $display("FAIL sum_release got v%b r%b c%0d want v0 r1 c0",
               out_valid, in_ready, out_count);
    else pass_cnt++;
  endtask

  task automatic test_single_sub();
    beat(32'hC0000000, 1'b1, 1'b1);
    total_cnt++;
    if (out_valid !== 1'b1)
      $display("FAIL single_valid got %b want 1", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 32'h40000000)
      $display("FAIL single_data got %h want 40000000", out_data);
    else pass_cnt++;
    total_cnt++;
    if ({out_count, out_underflow, out_overflow, out_invalid}
        !== {16'd1, 3'b000})
      $display("FAIL single_cnt_flags got %0d/%b want 1/000", out_count,
               {out_underflow, out_overflow, out_invalid});
    else pass_cnt++;
    take();
  endtask

  task automatic test_invalid();
    beat(32'h7F800000, 1'b0, 1'b0);
    beat(32'hFF800000, 1'b0, 1'b1);
    total_cnt++;
    if (out_data !== 32'hFFC00000)
      $display("FAIL inv_data got %h want ffc00000", out_data);
    else pass_cnt++;
    total_cnt++;
    if ({out_underflow, out_overflow, out_invalid} !== 3'b001)
      $display("FAIL inv_flags got %b want 001",
               {out_underflow, out_overflow, out_invalid});
    else pass_cnt++;
    take();
  endtask

  task automatic test_overflow();
    beat(32'h7F7FFFFF, 1'b0, 1'b0);
    beat(32'h7F7FFFFF, 1'b0, 1'b1);
    total_cnt++;
    if (out_data !== 32'h7F800000)
      $display("FAIL ovf_data got %h want 7f800000", out_data);
    else pass_cnt++;
    total_cnt++;
    if ({out_underflow, out_overflow, out_invalid} !== 3'b010)
      $display("FAIL ovf_flags got %b want 010",
               {out_underflow, out_overflow, out_invalid});
    else pass_cnt++;
    take();
  endtask

  task automatic test_back_to_back();
    beat(32'h40A00000, 1'b0, 1'b0);
    beat(32'h40000000, 1'b1, 1'b1);
    total_cnt++;
    if ({out_data, out_count} !== {32'h40400000, 16'd2})
      $display("FAIL b2b_sub got %h/%0d want 40400000/2",
               out_data, out_count);
    else pass_cnt++;
    take();
    beat(32'h3F800000, 1'b0, 1'b0);
    beat(32'h3F800000, 1'b1, 1'b1);
    total_cnt++;
    if ({out_data, out_count} !== {32'h00000000, 16'd2})
      $display("FAIL b2b_cancel got %h/%0d want 00000000/2",
               out_data, out_count);
    else pass_cnt++;
    take();
  endtask

  task automatic test_hold();
    logic [50:0] snap;
    logic        rdy_seen;
    logic        changed;
    beat(32'h3F800000, 1'b0, 1'b0);
    beat(32'h3F800000, 1'b0, 1'b1);
    snap = {out_valid, out_data, out_count,
            out_underflow, out_overflow};
    rdy_seen = 1'b0;
    changed  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h12345678;
      in_last  = 1'b1;
      #1;
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      if ({out_valid, out_data, out_count, out_underflow,
           out_overflow} !== snap || out_invalid !== 1'b0)
        changed = 1'b1;
    end
    total_cnt++;
    if (rdy_seen !== 1'b0)
      $display("FAIL hold_ready got 1 want 0");
    else pass_cnt++;
    total_cnt++;
    if (changed !== 1'b0 || out_data !== 32'h40000000)
      $display("FAIL hold_stable got %h/%0d want 40000000/2",
               out_data, out_count);
    else pass_cnt++;
    take();
    in_valid = 1'b0;
    in_last  = 1'b0;
    total_cnt++;
    if (out_count !== 16'd0)
      $display("FAIL hold_clear got %0d want 0", out_count);
    else pass_cnt++;
    beat(32'h3F800000, 1'b0, 1'b1);
    total_cnt++;
    if ({out_valid, out_data, out_count} !== {1'b1, 32'h3F800000, 16'd1})
      $display("FAIL hold_next got v%b %h/%0d want v1 3f800000/1",
               out_valid, out_data, out_count);
    else pass_cnt++;
    total_cnt++;
    if ({out_underflow, out_overflow, out_invalid} !== 3'b000)
      $display("FAIL hold_next_flags got %b want 000",
               {out_underflow, out_overflow, out_invalid});
    else pass_cnt++;
    take();
  endtask

  task automatic test_reset_mid();
    beat(32'h3F800000, 1'b0, 1'b0);
    beat(32'h40000000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, in_ready, out_count, out_data} !== 50'h0)
      $display("FAIL midrst got v%b r%b %0d %h want all 0",
               out_valid, in_ready, out_count, out_data);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    beat(32'h40000000, 1'b0, 1'b0);
    beat(32'h40400000, 1'b0, 1'b1);
    total_cnt++;
    if ({out_valid, out_data, out_count} !== {1'b1, 32'h40A00000, 16'd2})
      $display("FAIL midrst_sum got v%b %h/%0d want v1 40a00000/2",
               out_valid, out_data, out_count);
    else pass_cnt++;
    take();
  endtask

  initial begin
    in_valid    = 1'b0;
    in_data     = '0;
    in_subtract = 1'b0;
    in_last     = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_sum();
    test_single_sub();
    test_invalid();
    test_overflow();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
